// File: rtl/shifter_video_feeder_pkg.sv
// Shared definitions for the shifter video feeder: bus slot timing,
// default address width and the fetch FSM state encoding.
package shifter_video_feeder_pkg;

  localparam int SLOT_CLKS  = 16;
  localparam int AW_DEFAULT = 22;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/video_word_fifo.sv
// Synchronous word FIFO between the RAM fetch side and the shifter LOAD side.
// Flush empties it in one cycle; pop on empty is ignored.
module video_word_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic                         clk32,
  input  logic                         nReset,
  input  logic                         push_i,
  input  logic [W-1:0]                 data_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  output logic [W-1:0]                 data_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] rd_q, wr_q;
  logic [CW-1:0] count_q;
  logic          do_pop;

  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

  // NOTE: the storage array has no reset; only pointers and count define validity.
  always_ff @(posedge clk32) begin
    if (push_i) mem_q[wr_q] <= data_i;
  end

  always_ff @(posedge clk32 or negedge nReset) begin
    if (!nReset) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + PW'(1);
      if (do_pop) rd_q <= rd_q + PW'(1);
      case ({push_i, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/shifter_video_feeder.sv
// Fetches screen words from RAM into a small FIFO and presents them to the
// shifter as LOAD/DIN, one word per 2 MHz bus slot while DE is high.
module shifter_video_feeder
  import shifter_video_feeder_pkg::*;
#(
  parameter int AW     = AW_DEFAULT,
  parameter int DEPTH  = 4,
  parameter int LOAD_W = 8
) (
  input  logic          clk32,
  input  logic          nReset,
  input  logic          slot,
  input  logic          vsync,
  input  logic [AW-1:0] vbase,
  input  logic [7:0]    line_offset,
  input  logic          fetch,
  input  logic          DE,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [15:0]   mem_data,
  output logic          LOAD,
  output logic [15:0]   DIN,
  output logic [AW-1:0] vaddr,
  output logic          underflow
);

  localparam int CW  = $clog2(DEPTH+1);
  localparam int LCW = $clog2(SLOT_CLKS);

  logic          vsync_q, fetch_q, de_q;
  logic          vsync_rise, fetch_fall, de_fall;
  fetch_state_e  state_q;
  logic          mem_req_q;
  logic [AW-1:0] mem_addr_q, vaddr_q, vaddr_d;
  logic          load_q, underflow_q;
  logic [LCW-1:0] load_cnt_q;
  logic [15:0]   din_q, fifo_head;
  logic          push, pop, flush, load_slot, start_req;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   occupancy;

  assign vsync_rise = vsync & ~vsync_q;
  assign fetch_fall = ~fetch & fetch_q;
  assign de_fall    = ~DE & de_q;

  // Words already in the FIFO plus the one still on the bus.
  assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, (state_q == REQ)};
  assign start_req = (state_q == IDLE) && slot && fetch && (occupancy < (CW+1)'(DEPTH));
  assign push      = (state_q == REQ) && mem_ack;
  assign load_slot = slot && DE;
  assign pop       = load_slot && !fifo_empty;
  assign flush     = vsync_rise || de_fall;

  video_word_fifo #(.DEPTH(DEPTH), .W(16)) u_fifo (
    .clk32   (clk32),
    .nReset  (nReset),
    .push_i  (push),
    .data_i  (mem_data),
    .pop_i   (pop),
    .flush_i (flush),
    .data_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // NOTE: give every always_comb output a default first so no latch is inferred.
  always_comb begin
    vaddr_d = vaddr_q;
    if (push)       vaddr_d = vaddr_d + AW'(1);
    if (fetch_fall) vaddr_d = vaddr_d + AW'(line_offset);
    if (vsync_rise) vaddr_d = vbase;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk32 or negedge nReset) begin
    if (!nReset) begin
      vsync_q <= 1'b0;
      fetch_q <= 1'b0;
      de_q    <= 1'b0;
      vaddr_q <= '0;
    end else begin
      vsync_q <= vsync;
      fetch_q <= fetch;
      de_q    <= DE;
      vaddr_q <= vaddr_d;
    end
  end

  always_ff @(posedge clk32 or negedge nReset) begin
    if (!nReset) begin
      state_q    <= IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (start_req) begin
          mem_addr_q <= vaddr_q;
          mem_req_q  <= 1'b1;
          state_q    <= REQ;
        end
        REQ: if (mem_ack) begin
          mem_req_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  // LOAD rises the cycle after a DE slot; the pop and DIN update land on that edge.
  always_ff @(posedge clk32 or negedge nReset) begin
    if (!nReset) begin
      load_q      <= 1'b0;
      load_cnt_q  <= '0;
      din_q       <= '0;
      underflow_q <= 1'b0;
    end else begin
      if (load_slot) begin
        load_q     <= 1'b1;
        load_cnt_q <= LCW'(LOAD_W - 1);
        din_q      <= fifo_empty ? 16'h0000 : fifo_head;
      end else if (load_q) begin
        if (load_cnt_q == '0) load_q <= 1'b0;
        else                  load_cnt_q <= load_cnt_q - LCW'(1);
      end
      if (vsync_rise)                   underflow_q <= 1'b0;
      else if (load_slot && fifo_empty) underflow_q <= 1'b1;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign LOAD      = load_q;
  assign DIN       = din_q;
  assign vaddr     = vaddr_q;
  assign underflow = underflow_q;

  push_never_full: assert property (@(posedge clk32) disable iff (!nReset) !(push && fifo_full));

endmodule

// File: tb/tb_shifter_video_feeder.sv
// Scoreboard bench for shifter_video_feeder: directed lines push expected DIN
// words; a monitor pops and checks them on every LOAD rise.
module tb_shifter_video_feeder;

  localparam int AW     = 22;
  localparam int DEPTH  = 4;
  localparam int LOAD_W = 8;

  logic          clk32 = 1'b0;
  logic          nReset = 1'b1;
  logic          slot;
  logic          vsync = 1'b0;
  logic [AW-1:0] vbase = '0;
  logic [7:0]    line_offset = '0;
  logic          fetch = 1'b0;
  logic          DE = 1'b0;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack = 1'b0;
  logic [15:0]   mem_data = '0;
  logic          LOAD;
  logic [15:0]   DIN;
  logic [AW-1:0] vaddr;
  logic          underflow;

  shifter_video_feeder #(.AW(AW), .DEPTH(DEPTH), .LOAD_W(LOAD_W)) dut (
    .clk32       (clk32),
    .nReset      (nReset),
    .slot        (slot),
    .vsync       (vsync),
    .vbase       (vbase),
    .line_offset (line_offset),
    .fetch       (fetch),
    .DE          (DE),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_data    (mem_data),
    .LOAD        (LOAD),
    .DIN         (DIN),
    .vaddr       (vaddr),
    .underflow   (underflow)
  );

  always #5 clk32 = ~clk32;

  // Slot strobe: one cycle in sixteen, changing just after the rising edge.
  logic [3:0] phase_q = '0;
  always @(posedge clk32) phase_q <= phase_q + 4'd1;
  assign slot = (phase_q == 4'd15);

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // RAM model: ack two clk32 after the request edge, data = address low bits.
  logic withhold = 1'b0;
  logic stale_ack = 1'b0;
  int   age = 0;
  always @(posedge clk32) begin
    #1;
    mem_ack = 1'b0;
    if (stale_ack) mem_ack = 1'b1;
    else if (!mem_req) age = 0;
    else if (age >= 1 && !withhold) begin
      mem_ack  = 1'b1;
      mem_data = mem_addr[15:0];
    end else age = 1;
  end

  // Monitor: DIN vs scoreboard, LOAD latency, width and spacing.
  logic load_prev = 1'b0;
  logic slot_prev = 1'b0;
  int   width = 0, last_rise = -1, ncyc = 0, load_count = 0;
  always @(negedge clk32) begin
    ncyc++;
    if (LOAD && !load_prev) begin
      load_count++;
      check("load_latency", slot_prev, 1);
      if (last_rise >= 0 && ncyc - last_rise <= 32) check("load_spacing", ncyc - last_rise, 16);
      last_rise = ncyc;
      if (exp_q.size() == 0) check("unexpected_load", exp_q.size(), 1);
      else check("din", DIN, exp_q.pop_front());
      width = 1;
    end else if (LOAD) width++;
    else if (load_prev) check("load_width", width, LOAD_W);
    load_prev = LOAD;
    slot_prev = slot;
  end

  task automatic wait_slot();
    int guard = 0;
    do begin
      @(negedge clk32);
      guard++;
    end while (slot !== 1'b1 && guard < 64);
    if (guard >= 64) check("slot_timeout", guard, 0);
  endtask

  task automatic vsync_pulse(input logic [AW-1:0] b);
    @(negedge clk32);
    vbase = b;
    vsync = 1'b1;
    @(negedge clk32);
    check("vsync_vaddr", vaddr, b);
    check("vsync_underflow", underflow, 0);
    check("vsync_load", LOAD, 0);
    check("vsync_mem_req", mem_req, 0);
    vsync = 1'b0;
  endtask

  // Expected DIN at slot i of a line (DE slots start at 3). For the withheld
  // line the ack for the request made at slot wh arrives one edge after slot
  // wh+4, so slots wh+3 and wh+4 starve, later slots run two words behind,
  // and the last two DE slots find the FIFO empty after fetch ends.
  function automatic logic [15:0] exp_word(int i, logic [AW-1:0] base, int n_fetch, int wh);
    logic [AW-1:0] a;
    if (wh < 0) begin
      a = base + AW'(i - 3);
      return (i - 3 < n_fetch) ? a[15:0] : 16'h0000;
    end
    if (i <= wh + 2) begin
      a = base + AW'(i - 3);
      return a[15:0];
    end
    if (i <= wh + 4) return 16'h0000;
    if (i <= n_fetch) begin
      a = base + AW'(i - 5);
      return a[15:0];
    end
    return 16'h0000;
  endfunction

  task automatic run_line(input logic [AW-1:0] base, input int n_fetch, input int de_end,
                          input int wh, input int leftover, input logic [AW-1:0] vaddr_exp);
    int lc0;
    lc0 = load_count;
    for (int i = 0; i <= de_end; i++) begin
      wait_slot();
      fetch = (i < n_fetch);
      DE    = (i >= 3 && i < de_end);
      if (DE) exp_q.push_back(exp_word(i, base, n_fetch, wh));
      if (i == wh) withhold = 1'b1;
      if (wh >= 0 && i == wh + 4) withhold = 1'b0;
      if (i == de_end) check("count_before_flush", dut.u_fifo.count_o, leftover);
      if (i == 0) begin
        @(negedge clk32);
        check("first_mem_req", mem_req, 1);
        check("first_mem_addr", mem_addr, base);
      end
    end
    @(negedge clk32);
    check("count_after_flush", dut.u_fifo.count_o, 0);
    check("load_pulses", load_count - lc0, de_end - 3);
    check("vaddr_eol", vaddr, vaddr_exp);
    check("exp_drained", exp_q.size(), 0);
  endtask

  initial begin
    #1 nReset = 1'b0;
    repeat (3) @(negedge clk32);
    check("rst_vaddr", vaddr, 0);
    check("rst_load", LOAD, 0);
    check("rst_din", DIN, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_underflow", underflow, 0);
    nReset = 1'b1;

    // Plain 80-word line.
    vsync_pulse(22'h01000);
    run_line(22'h01000, 80, 83, -1, 0, 22'h01050);
    check("line1_underflow", underflow, 0);

    // Line offset of 4 words across two lines.
    line_offset = 8'd4;
    vsync_pulse(22'h02000);
    run_line(22'h02000, 80, 83, -1, 0, 22'h02054);
    run_line(22'h02054, 80, 83, -1, 0, 22'h020A8);

    // Withheld ack: FIFO drains, underflow stays set until vsync.
    line_offset = 8'd0;
    vsync_pulse(22'h03000);
    run_line(22'h03000, 80, 83, 20, 0, 22'h0304C);
    check("underflow_set", underflow, 1);
    repeat (100) @(negedge clk32);
    check("underflow_sticky", underflow, 1);

    // DE falls with two prefetched words; next line starts fresh.
    vsync_pulse(22'h04000);
    run_line(22'h04000, 10, 11, -1, 2, 22'h0400A);
    run_line(22'h0400A, 80, 83, -1, 0, 22'h0405A);

    // Reset while a request is outstanding, then a stale ack.
    vsync_pulse(22'h05000);
    wait_slot();
    fetch = 1'b1;
    withhold = 1'b1;
    @(negedge clk32);
    check("pre_reset_mem_req", mem_req, 1);
    repeat (3) @(negedge clk32);
    nReset = 1'b0;
    fetch = 1'b0;
    #1;
    check("midrst_mem_req", mem_req, 0);
    check("midrst_load", LOAD, 0);
    check("midrst_vaddr", vaddr, 0);
    repeat (3) @(negedge clk32);
    nReset = 1'b1;
    withhold = 1'b0;
    @(negedge clk32);
    stale_ack = 1'b1;
    @(negedge clk32);
    stale_ack = 1'b0;
    repeat (2) @(negedge clk32);
    check("stale_ack_count", dut.u_fifo.count_o, 0);
    check("stale_ack_mem_req", mem_req, 0);
    check("stale_ack_vaddr", vaddr, 0);

    repeat (20) @(negedge clk32);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
